// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared state encoding, error data and default parameters
package mem_responder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;
  localparam int DEF_LATENCY = 2;
  localparam int DEF_AW = 8;
endpackage

// File: rtl/mem_responder_ram.sv
// mem_responder_ram: 2^AW x 32 storage, byte-enabled sync write, sync read, no reset
module mem_responder_ram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency memory slave with byte writes, range check and saturating counters
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int AW = DEF_AW
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        addr_err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic ready_q, ready_d, err_q, err_d, ram_sel_q, ram_sel_d;
  logic [15:0] rd_q, rd_d, wr_q, wr_d;
  logic capture, go_resp, oor, is_wr;
  logic [31:0] cur_addr, cur_wdata, ram_rdata;
  logic [3:0] cur_wstrb;
  // With LATENCY=0 the access completes at the capture edge, so the live inputs feed the RAM
  always_comb begin
    capture = state_q == IDLE && mem_valid;
    cur_addr = state_q == IDLE ? mem_addr : addr_q;
    cur_wdata = state_q == IDLE ? mem_wdata : wdata_q;
    cur_wstrb = state_q == IDLE ? mem_wstrb : wstrb_q;
    go_resp = LATENCY == 0 ? capture : state_q == WAIT && cnt_q == '0;
    oor = (cur_addr >> (AW + 2)) != '0;
    is_wr = cur_wstrb != '0;
    state_d = go_resp ? RESP : capture ? WAIT : state_q == RESP ? IDLE : state_q;
    cnt_d = capture ? CW'(LATENCY > 0 ? LATENCY - 1 : 0) :
            (state_q == WAIT && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    addr_d = capture ? mem_addr : addr_q;
    wdata_d = capture ? mem_wdata : wdata_q;
    wstrb_d = capture ? mem_wstrb : wstrb_q;
    ready_d = go_resp;
    err_d = go_resp && oor;
    ram_sel_d = go_resp ? !is_wr && !oor : ram_sel_q;
    rdata_d = go_resp ? (oor ? ERR_DATA : 32'h0) : rdata_q;
    rd_d = (go_resp && !is_wr && rd_q != 16'hFFFF) ? rd_q + 16'd1 : rd_q;
    wr_d = (go_resp && is_wr && wr_q != 16'hFFFF) ? wr_q + 16'd1 : wr_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      ready_q <= 1'b0;
      err_q <= 1'b0;
      ram_sel_q <= 1'b0;
      rdata_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      ready_q <= ready_d;
      err_q <= err_d;
      ram_sel_q <= ram_sel_d;
      rdata_q <= rdata_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
    end
  end
  // RAM output register holds the last read word until the next in-range read
  mem_responder_ram #(.AW(AW)) u_ram (
    .clk  (clk),
    .we   (go_resp && is_wr && !oor),
    .re   (go_resp && !is_wr && !oor),
    .be   (cur_wstrb),
    .addr (cur_addr[AW+1:2]),
    .wdata(cur_wdata),
    .rdata(ram_rdata)
  );
  assign mem_ready = ready_q;
  assign addr_err = err_q;
  assign mem_rdata = ram_sel_q ? ram_rdata : rdata_q;
  assign rd_count = rd_q;
  assign wr_count = wr_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scoreboard bench for LATENCY=2 and LATENCY=0 instances
module tb_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_valid = 1'b0, b_valid = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0, b_addr = '0, b_wdata = '0;
  logic [3:0] mem_wstrb = '0, b_wstrb = '0;
  logic mem_ready, addr_err, b_ready, b_err;
  logic [31:0] mem_rdata, b_rdata;
  logic [15:0] rd_count, wr_count, b_rd_count, b_wr_count;
  int checks = 0;
  int failures = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp_b[$];

  always #5 clk = ~clk;

  mem_responder dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .addr_err(addr_err), .rd_count(rd_count), .wr_count(wr_count)
  );

  mem_responder #(.LATENCY(0)) dut_b (
    .clk(clk), .reset(reset), .mem_valid(b_valid), .mem_addr(b_addr),
    .mem_wstrb(b_wstrb), .mem_wdata(b_wdata), .mem_ready(b_ready),
    .mem_rdata(b_rdata), .addr_err(b_err), .rd_count(b_rd_count), .wr_count(b_wr_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL a_unexpected_ready: observed ready with empty scoreboard");
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("a_rdata", mem_rdata, e[31:0]);
        chk("a_err", 32'(addr_err), 32'(e[32]));
      end
    end
    if (b_ready === 1'b1) begin
      if (exp_b.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL b_unexpected_ready: observed ready with empty scoreboard");
      end else begin
        logic [32:0] e;
        e = exp_b.pop_front();
        chk("b_rdata", b_rdata, e[31:0]);
        chk("b_err", 32'(b_err), 32'(e[32]));
      end
    end
  end

  task automatic xfer(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                      input logic [31:0] er, input logic ee);
    int n;
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = a; mem_wstrb = s; mem_wdata = d;
    exp_q.push_back({ee, er});
    @(posedge clk);
    #1;
    mem_valid = 1'b0; mem_addr = $urandom; mem_wstrb = 4'($urandom); mem_wdata = $urandom;
    n = 0;
    while (mem_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("a_latency", 32'(n), 32'd3);
    @(negedge clk);
    chk("a_ready_one_cycle", 32'(mem_ready), 32'd0);
    chk("a_err_one_cycle", 32'(addr_err), 32'd0);
  endtask

  initial begin
    int pulses, last, gap_bad, seen, exp_rd, exp_wr;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(mem_ready), 32'd0);
    chk("rst_err", 32'(addr_err), 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_rd_count", 32'(rd_count), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    reset = 1'b0;
    xfer(32'h10, 4'b1111, 32'h3, 32'h0, 1'b0);
    chk("wr_count_1", 32'(wr_count), 32'd1);
    xfer(32'h10, 4'b0000, 32'h0, 32'h3, 1'b0);
    chk("rd_count_1", 32'(rd_count), 32'd1);
    xfer(32'h10, 4'b0010, 32'h0000AB00, 32'h0, 1'b0);
    xfer(32'h10, 4'b0000, 32'h0, 32'h0000AB03, 1'b0);
    repeat (3) @(negedge clk);
    chk("rdata_hold", mem_rdata, 32'h0000AB03);
    xfer(32'h13, 4'b0000, 32'h0, 32'h0000AB03, 1'b0);
    xfer(32'h1000, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b1);
    xfer(32'h1010, 4'b1111, 32'hFFFFFFFF, 32'hDEADBEEF, 1'b1);
    xfer(32'h10, 4'b0000, 32'h0, 32'h0000AB03, 1'b0);
    exp_rd = 5; exp_wr = 3;
    chk("rd_count_seq", 32'(rd_count), 32'(exp_rd));
    chk("wr_count_seq", 32'(wr_count), 32'(exp_wr));
    // held-valid write stream: address advances by 4 every cycle, wrapped into range
    for (int k = 0; k < 125; k++) exp_q.push_back({1'b0, 32'h0});
    pulses = 0; last = -1; gap_bad = 0;
    mem_wstrb = 4'hF;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (mem_ready === 1'b1) begin
        if (last >= 0 && c - last != 4) gap_bad++;
        last = c;
        pulses++;
      end
      mem_valid = 1'b1;
      mem_addr = (32'(c) * 32'd4) & 32'h3FF;
      mem_wdata = 32'hC0DE0000 | mem_addr;
    end
    @(posedge clk);
    #1 mem_valid = 1'b0;
    @(negedge clk);
    exp_wr += 125;
    chk("stream_pulses", 32'(pulses), 32'd125);
    chk("stream_gap", 32'(gap_bad), 32'd0);
    chk("stream_wr_count", 32'(wr_count), 32'(exp_wr));
    xfer(32'h50, 4'b0000, 32'h0, 32'hC0DE0050, 1'b0);
    // reset while the next request sits in WAIT
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h20; mem_wstrb = 4'hF; mem_wdata = 32'hBAD0BAD0;
    @(posedge clk);
    #1 mem_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("wrst_ready", 32'(mem_ready), 32'd0);
    chk("wrst_err", 32'(addr_err), 32'd0);
    chk("wrst_rdata", mem_rdata, 32'd0);
    chk("wrst_rd_count", 32'(rd_count), 32'd0);
    chk("wrst_wr_count", 32'(wr_count), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_ready !== 1'b0) seen++;
    end
    chk("wrst_no_ready", 32'(seen), 32'd0);
    xfer(32'h20, 4'b0000, 32'h0, 32'hC0DE0020, 1'b0);
    chk("wrst_rd_count_after", 32'(rd_count), 32'd1);
    chk("wrst_wr_count_after", 32'(wr_count), 32'd0);
    // LATENCY=0 instance
    @(negedge clk);
    b_valid = 1'b1; b_addr = 32'h8; b_wstrb = 4'hF; b_wdata = 32'h77;
    exp_b.push_back({1'b0, 32'h0});
    @(posedge clk);
    #1;
    chk("b_ready_at_capture", 32'(b_ready), 32'd1);
    b_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("b_ready_low", 32'(b_ready), 32'd0);
    for (int k = 0; k < 10; k++) exp_b.push_back({1'b0, 32'h77});
    pulses = 0; last = -1; gap_bad = 0;
    b_wstrb = 4'h0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (b_ready === 1'b1) begin
        if (last >= 0 && c - last != 2) gap_bad++;
        last = c;
        pulses++;
      end
      b_valid = 1'b1;
    end
    @(posedge clk);
    #1 b_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("b_pulses", 32'(pulses), 32'd10);
    chk("b_gap", 32'(gap_bad), 32'd0);
    chk("b_rd_count", 32'(b_rd_count), 32'd10);
    chk("b_wr_count", 32'(b_wr_count), 32'd1);
    chk("a_sb_drain", 32'(exp_q.size()), 32'd0);
    chk("b_sb_drain", 32'(exp_b.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, wait cycles between request capture and mem_ready.
REQ-002 SHALL have parameter AW, default 8, word-address width, giving 2^AW words of storage.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 mem_valid  input  1  request present.
REQ-007 mem_addr  input  32  byte address.
REQ-008 mem_wstrb  input  4  byte write strobes; 4'b0000 means read.
REQ-009 mem_wdata  input  32  write data.
REQ-010 mem_ready  output  1  registered; one-cycle completion pulse.
REQ-011 mem_rdata  output  32  registered read data, valid while mem_ready=1.
REQ-012 addr_err  output  1  registered; pulses with mem_ready on an out-of-range access.
REQ-013 rd_count  output  16  completed reads, saturating.
REQ-014 wr_count  output  16  completed writes, saturating.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 IDLE + mem_valid=1 at edge t0: SHALL capture mem_addr, mem_wstrb and mem_wdata.
REQ-017 At that edge SHALL go to WAIT if LATENCY>0, else to RESP.
REQ-018 WAIT SHALL load a down-counter with LATENCY-1 on entry and go to RESP when it reaches 0.
REQ-019 mem_ready SHALL rise at edge t0+LATENCY and fall at edge t0+LATENCY+1 (exactly one cycle high).
REQ-020 RESP SHALL return to IDLE unconditionally and ignore mem_valid in that cycle.
REQ-021 Throughput: one transfer per LATENCY+2 cycles when mem_valid is held high.
REQ-022 Changes to mem_valid, mem_addr, mem_wstrb or mem_wdata after capture SHALL be ignored; a captured request always completes.
REQ-023 Word index SHALL be captured mem_addr[AW+1:2].
REQ-024 mem_addr[1:0] SHALL be ignored.
REQ-025 Out of range means mem_addr[31:AW+2] != 0.
REQ-026 Write (wstrb != 0), in range: at the RESP-entry edge, write only the bytes whose strobe is set (wstrb[i] covers bits 8i+7:8i); mem_rdata <= 0.
REQ-027 Read (wstrb = 0), in range: at the RESP-entry edge, mem_rdata <= stored word.
REQ-028 A read following a write to the same word SHALL return the merged new word.
REQ-029 Out of range: SHALL suppress the write, set mem_rdata <= 32'hDEADBEEF, assert addr_err with mem_ready, and still count the transfer.
REQ-030 mem_rdata SHALL hold its value outside RESP.
REQ-031 Counters SHALL increment at the RESP-entry edge and saturate at 16'hFFFF.

Reset
REQ-032 reset=1 SHALL immediately force IDLE, mem_ready=0, addr_err=0, mem_rdata=0, rd_count=0, wr_count=0, wait counter=0.
REQ-033 Reset during WAIT or RESP SHALL abort the transfer: no write, no count, no ready.
REQ-034 Storage contents SHALL NOT be cleared by reset; they are undefined after power-up.

Structure
REQ-035 A shared package SHALL hold the state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2), ERR_DATA=32'hDEADBEEF and the default LATENCY/AW.
REQ-036 Storage SHALL be a sub-module mem_responder_ram: 2^AW x 32, synchronous write with 4 byte enables, synchronous read, no reset.

Verification
REQ-037 LATENCY=2: write addr 0x10, wstrb 4'b1111, data 0x00000003 at t0 -> ready high only in the cycle after edge t0+2; wr_count=1; rdata=0.
REQ-038 Read addr 0x10 -> rdata=0x00000003 with ready; rd_count=1; addr_err=0.
REQ-039 Write addr 0x10, wstrb 4'b0010, data 0x0000AB00, then read -> rdata=0x0000AB03.
REQ-040 Read addr 0x00001000 (AW=8) -> rdata=0xDEADBEEF, addr_err=1 for one cycle, storage unchanged.
REQ-041 mem_valid held high for 500 writes incrementing by 4 -> 125 ready pulses spaced 4 cycles apart; reset asserted during WAIT -> ready stays 0, outputs and counts cleared.
REQ-042 LATENCY=0 -> ready rises at the capture edge; back-to-back transfers come every 2 cycles.
